// File: rtl/fsk_byte_modulator.sv
// -----------------------------------------------------------------------------
// fsk_byte_modulator
//
// Transmit framer and FSK modulator. A byte accepted over valid/ready is sent
// as an asynchronous frame: start bit (0), 8 data bits LSB first, an optional
// even-parity bit, and a stop bit (1). Each line bit lasts BIT_CYCLES clocks.
// It is presented as an NCO phase increment: MARK_INC for 1/idle and
// SPACE_INC for 0.
//
// Build option:
//   FSK_PARITY_EN - when defined, adds the PARITY state. The frame is then
//                   11 bits long and carries even parity over the data byte.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   data_i     in   8   byte to send, sampled on handshake only
//   valid_i    in   1   data_i is valid
//   ready_o    out  1   block accepts a byte this cycle (registered)
//   phi_inc_o  out  32  NCO phase increment (registered)
//   bit_o      out  1   line bit being sent, 1 when idle (registered)
//   busy_o     out  1   frame in progress (registered)
//   done_o     out  1   one-cycle pulse in the first IDLE cycle after STOP
// -----------------------------------------------------------------------------
module fsk_byte_modulator #(
  parameter int          BIT_CYCLES = 125000,
  parameter logic [31:0] MARK_INC   = 32'd425201762,
  parameter logic [31:0] SPACE_INC  = 32'd433791697
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] phi_inc_o,
  output logic        bit_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int               CNT_W   = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef FSK_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

`ifdef FSK_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             bit_q, bit_d;
  logic [31:0]      phi_q, phi_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end_s;

  // Next-state logic: bit timing, frame sequencing and handshake capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    done_d    = 1'b0;
    bit_end_s = (cnt_q == CNT_MAX);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        // ready_q is high in IDLE, so this is the handshake
        if (valid_i && ready_q) begin
          state_d = S_START;
          data_d  = data_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
`ifdef FSK_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef FSK_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Output decode from the next state so that outputs change on the
  // same edge as the state (START is visible right after the handshake edge).
  always_comb begin
    bit_d = 1'b1;
    case (state_d)
      S_IDLE:   bit_d = 1'b1;
      S_START:  bit_d = 1'b0;
      S_DATA:   bit_d = data_d[idx_d];
`ifdef FSK_PARITY_EN
      S_PARITY: bit_d = even_parity(data_d);
`endif
      S_STOP:   bit_d = 1'b1;
      default:  bit_d = 1'b1;
    endcase
    phi_d   = bit_d ? MARK_INC : SPACE_INC;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      data_q  <= 8'd0;
      bit_q   <= 1'b1;
      phi_q   <= MARK_INC;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      phi_q   <= phi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready_o   = ready_q;
  assign phi_inc_o = phi_q;
  assign bit_o     = bit_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
